// File: rtl/fetch_queue.sv
// Instruction queue between IF and ID: circular buffer of {pc, inst} pairs with
// one-cycle flush, optional empty-queue bypass and a canonical NOP on empty slots.

module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [XLEN-1:0]            enq_pc,
    input  logic [XLEN-1:0]            enq_inst,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [XLEN-1:0] inst_mem_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic full_s;
    logic empty_s;
    logic bypass_s;
    logic deq_valid_s;
    logic enq_fire_s;
    logic deq_fire_s;
    logic push_s;
    logic pop_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    // The bypass path only exists when nothing is stored; stored entries always win.
    assign bypass_s    = BYPASS && empty_s && enq_valid;
    assign deq_valid_s = !flush && (!empty_s || bypass_s);
    assign enq_fire_s  = enq_valid && !full_s;
    assign deq_fire_s  = deq_valid_s && deq_ready;
    // A bypassed entry consumed in the same cycle never touches the buffer.
    assign push_s      = !flush && enq_fire_s && !(bypass_s && deq_fire_s);
    assign pop_s       = !flush && deq_fire_s && !empty_s;

    assign enq_ready   = !full_s;
    assign deq_valid   = deq_valid_s;
    assign count       = count_r;

    // Head selection: buffer head, bypassed enq data, or the canonical NOP.
    always_comb begin
        deq_pc   = {XLEN{1'b0}};
        deq_inst = NOP_INST;
        if (deq_valid_s) begin
            if (empty_s) begin
                deq_pc   = enq_pc;
                deq_inst = enq_inst;
            end else begin
                deq_pc   = pc_mem_r[rd_ptr_r];
                deq_inst = inst_mem_r[rd_ptr_r];
            end
        end else begin
            deq_pc   = {XLEN{1'b0}};
            deq_inst = NOP_INST;
        end
    end

    // Pointer and occupancy state; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            pc_mem_r[wr_ptr_r]   <= enq_pc;
            inst_mem_r[wr_ptr_r] <= enq_inst;
        end
    end

    fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .push_s  (push_s),
        .pop_s   (pop_s),
        .count_r (count_r)
    );
endmodule

// Occupancy sanity checks: the buffer is never popped empty nor pushed past full.
module fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input logic                       clk,
    input logic                       rst,
    input logic                       push_s,
    input logic                       pop_s,
    input logic [$clog2(DEPTH+1)-1:0] count_r
);
    localparam int CW = $clog2(DEPTH+1);

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(pop_s && (count_r == {CW{1'b0}})));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push_s && !pop_s && (count_r == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue: one instance without and one with
// bypass, both scored every cycle against a queue-based reference model.

module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        deq_ready = 1'b0;
    logic [31:0] enq_pc = 32'h0;
    logic [31:0] enq_inst = 32'h0;

    logic        enq_ready0, deq_valid0, enq_ready1, deq_valid1;
    logic [31:0] deq_pc0, deq_inst0, deq_pc1, deq_inst1;
    logic [2:0]  count0, count1;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;
    logic [63:0] mq0 [$];
    logic [63:0] mq1 [$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready0), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .deq_valid(deq_valid0), .deq_ready(deq_ready), .deq_pc(deq_pc0), .deq_inst(deq_inst0),
        .count(count0)
    );

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready1), .enq_pc(enq_pc), .enq_inst(enq_inst),
        .deq_valid(deq_valid1), .deq_ready(deq_ready), .deq_pc(deq_pc1), .deq_inst(deq_inst1),
        .count(count1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare one instance against the model, then advance the model by one edge.
    task automatic model_step(input bit sel);
        logic [63:0] q [$];
        bit          byp, dv, rdy, do_deq, do_enq;
        logic [31:0] epc, einst;
        if (sel) q = mq1; else q = mq0;
        rdy   = (q.size() < DEPTH);
        byp   = sel && (q.size() == 0) && enq_valid;
        dv    = !flush && ((q.size() > 0) || byp);
        epc   = 32'h0;
        einst = NOP;
        if (dv) begin
            if (q.size() > 0) begin
                epc   = q[0][63:32];
                einst = q[0][31:0];
            end else begin
                epc   = enq_pc;
                einst = enq_inst;
            end
        end
        if (armed) begin
            if (sel) begin
                check_val("b1_count", 64'(count1), 64'(q.size()));
                check_val("b1_enq_ready", 64'(enq_ready1), 64'(rdy));
                check_val("b1_deq_valid", 64'(deq_valid1), 64'(dv));
                check_val("b1_deq_pc", 64'(deq_pc1), 64'(epc));
                check_val("b1_deq_inst", 64'(deq_inst1), 64'(einst));
            end else begin
                check_val("b0_count", 64'(count0), 64'(q.size()));
                check_val("b0_enq_ready", 64'(enq_ready0), 64'(rdy));
                check_val("b0_deq_valid", 64'(deq_valid0), 64'(dv));
                check_val("b0_deq_pc", 64'(deq_pc0), 64'(epc));
                check_val("b0_deq_inst", 64'(deq_inst0), 64'(einst));
            end
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            do_deq = dv && deq_ready;
            do_enq = enq_valid && rdy;
            if (!(byp && do_deq)) begin
                if (do_deq) void'(q.pop_front());
                if (do_enq) q.push_back({enq_pc, enq_inst});
            end
        end
        if (sel) mq1 = q; else mq0 = q;
    endtask

    task automatic tick();
        #1;
        model_step(1'b0);
        model_step(1'b1);
        @(posedge clk);
        if (rst) armed = 1'b1;
        #1;
    endtask

    initial begin
        @(negedge clk);
        // Reset held for two cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_val("rst_count", 64'(count0), 64'd0);
        check_val("rst_enq_ready", 64'(enq_ready0), 64'd1);
        check_val("rst_deq_valid", 64'(deq_valid0), 64'd0);
        check_val("rst_deq_inst", 64'(deq_inst0), 64'h13);
        check_val("rst_deq_pc", 64'(deq_pc0), 64'd0);

        // Fill to full, then an ignored fifth push.
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_pc   = 32'h60 + 32'(4 * i);
            enq_inst = 32'hA000_0000 + 32'(i);
            tick();
        end
        check_val("fill_count", 64'(count0), 64'd4);
        check_val("fill_enq_ready", 64'(enq_ready0), 64'd0);
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("drain_pc", 64'(deq_pc0), 64'(32'h60 + 32'(4 * i)));
            tick();
        end
        check_val("drain_empty", 64'(deq_valid0), 64'd0);

        // Wrap: three queued, then ten 1:1 push/pop cycles.
        deq_ready = 1'b0;
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_pc   = 32'h100 + 32'(4 * i);
            enq_inst = 32'hB000_0000 + 32'(i);
            tick();
        end
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_pc   = 32'h10C + 32'(4 * i);
            enq_inst = 32'hB000_0003 + 32'(i);
            #1;
            check_val("wrap_pc", 64'(deq_pc0), 64'(32'h100 + 32'(4 * i)));
            tick();
            check_val("wrap_count", 64'(count0), 64'd3);
        end

        // Flush with a concurrent push.
        flush    = 1'b1;
        enq_pc   = 32'h999;
        enq_inst = 32'hDEAD_BEEF;
        #1;
        check_val("flush_dv0", 64'(deq_valid0), 64'd0);
        check_val("flush_dv1", 64'(deq_valid1), 64'd0);
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        #1;
        check_val("flush_count", 64'(count0), 64'd0);
        check_val("flush_dv_after", 64'(deq_valid0), 64'd0);

        // Bypass consumed, then bypass presented but not taken.
        enq_valid = 1'b1;
        enq_pc    = 32'h80;
        enq_inst  = 32'h0050_0093;
        deq_ready = 1'b1;
        #1;
        check_val("byp_dv", 64'(deq_valid1), 64'd1);
        check_val("byp_inst", 64'(deq_inst1), 64'h0050_0093);
        check_val("byp_pc", 64'(deq_pc1), 64'h80);
        tick();
        check_val("byp_count0", 64'(count1), 64'd0);
        deq_ready = 1'b0;
        #1;
        check_val("byp_dv_stall", 64'(deq_valid1), 64'd1);
        tick();
        check_val("byp_count1", 64'(count1), 64'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 10000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            enq_valid = ($urandom_range(0, 3) != 0);
            deq_ready = (i % 2000 < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            enq_pc    = $urandom;
            enq_inst  = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
